// File: rtl/seg_lfsr_monitor.sv
// Decodes a two-digit active-low 7-segment display back to a byte and checks LFSR stepping.
// Optional saturating error counter built only when SEG_LFSR_MON_ERRCNT_EN is defined.
module seg_lfsr_monitor #(
    parameter int          STABLE_CYCLES = 4,
    parameter logic [7:0]  SEED          = 8'h01,
    parameter int          CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [13:0]      seg_in,
    output logic [7:0]       value,
    output logic             valid,
    output logic             bad_pattern,
    output logic             lfsr_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] SAT = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] PRE = SW'(STABLE_CYCLES - 1);

    localparam logic WAIT_FIRST = 1'b0;
    localparam logic TRACK      = 1'b1;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h01;
            4'h1: g = 7'h4F;
            4'h2: g = 7'h12;
            4'h3: g = 7'h06;
            4'h4: g = 7'h4C;
            4'h5: g = 7'h24;
            4'h6: g = 7'h20;
            4'h7: g = 7'h0F;
            4'h8: g = 7'h00;
            4'h9: g = 7'h04;
            4'hA: g = 7'h08;
            4'hB: g = 7'h60;
            4'hC: g = 7'h31;
            4'hD: g = 7'h42;
            4'hE: g = 7'h30;
            default: g = 7'h38;
        endcase
        return g;
    endfunction

    // Returns {legal, nibble}; nibble is don't-care when illegal.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] d;
        case (p)
            7'h01: d = 5'h10;
            7'h4F: d = 5'h11;
            7'h12: d = 5'h12;
            7'h06: d = 5'h13;
            7'h4C: d = 5'h14;
            7'h24: d = 5'h15;
            7'h20: d = 5'h16;
            7'h0F: d = 5'h17;
            7'h00: d = 5'h18;
            7'h04: d = 5'h19;
            7'h08: d = 5'h1A;
            7'h60: d = 5'h1B;
            7'h31: d = 5'h1C;
            7'h42: d = 5'h1D;
            7'h30: d = 5'h1E;
            7'h38: d = 5'h1F;
            default: d = 5'h00;
        endcase
        return d;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[4] ^ x[3] ^ x[2] ^ x[0], x[7:1]};
    endfunction

    localparam logic [13:0] SEED_SEG = {glyph(SEED[7:4]), glyph(SEED[3:0])};

    logic [13:0]   s1;
    logic [13:0]   s1_prev;
    logic [SW-1:0] stab_cnt;
    logic [7:0]    exp_val;
    logic          state;

    logic [4:0] dec_hi;
    logic [4:0] dec_lo;
    logic       legal;
    logic       same;
    logic [7:0] decoded;
    logic [7:0] cmp_val;
    logic       accept;

    always_comb begin
        dec_hi  = decode(s1[13:7]);
        dec_lo  = decode(s1[6:0]);
        legal   = dec_hi[4] & dec_lo[4];
        same    = (s1 == s1_prev);
        decoded = {dec_hi[3:0], dec_lo[3:0]};
        // The seed glyphs are implicitly accepted at reset, so the first
        // real accept must be the seed's successor.
        cmp_val = (state == WAIT_FIRST) ? lfsr_next(SEED) : exp_val;
        accept  = legal && same && (stab_cnt == PRE) && (decoded != value);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= SEED_SEG;
            s1_prev     <= SEED_SEG;
            stab_cnt    <= '0;
            bad_pattern <= 1'b0;
            value       <= SEED;
            valid       <= 1'b0;
            lfsr_err    <= 1'b0;
            exp_val     <= SEED;
            state       <= WAIT_FIRST;
        end else begin
            s1          <= seg_in;
            s1_prev     <= s1;
            bad_pattern <= ~legal;
            valid       <= accept;
            lfsr_err    <= accept && (decoded != cmp_val);
            if (!same || !legal)
                stab_cnt <= '0;
            else if (stab_cnt != SAT)
                stab_cnt <= stab_cnt + SW'(1);
            if (accept) begin
                value   <= decoded;
                exp_val <= lfsr_next(decoded);
                state   <= TRACK;
            end
        end
    end

`ifdef SEG_LFSR_MON_ERRCNT_EN
    logic bad_d;
    logic cnt_inc;

    assign cnt_inc = lfsr_err | (bad_pattern & ~bad_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            bad_d   <= 1'b0;
            err_cnt <= '0;
        end else begin
            bad_d <= bad_pattern;
            if (cnt_inc && err_cnt != {CNT_W{1'b1}})
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule
